// File: rtl/simif_feeder.sv
// CPU-to-simulator character feeder. It buffers characters written by the CPU and forwards
// each one to a downstream simulator port as a 0x70 command followed by the character.
module simif_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic             addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             s_cs,
  output logic             s_wen,
  output logic             s_addr,
  output logic [WIDTH-1:0] s_din,
  input  logic [WIDTH-1:0] s_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    DET_CMD,
    DET_RD,
    IDLE,
    PR_CMD,
    PR_CHAR
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          present_reg;
  logic          ovf_reg;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    head_reg;

  logic          empty;
  logic          full;
  logic          data_wr;
  logic          ctrl_wr;
  logic          push;
  logic          pop;
  logic          detect_req;
  logic          s_cs_dec;
  logic          s_wen_dec;
  logic [7:0]    s_char_dec;
  logic          unused_bits;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign data_wr    = cs & wen & ~addr;
  assign ctrl_wr    = cs & wen & addr;
  assign push       = reset & data_wr & ~full;
  assign detect_req = ctrl_wr & din[0];

  // A push into an empty FIFO starts printing right away, since the head is
  // only needed in PR_CHAR, one full cycle after it lands in memory.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      DET_CMD: state_next = DET_RD;
      DET_RD:  state_next = IDLE;
      IDLE: begin
        if (detect_req) begin
          state_next = DET_CMD;
        end else if (present_reg && (!empty || push)) begin
          state_next = PR_CMD;
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      PR_CMD:  state_next = PR_CHAR;
      PR_CHAR: begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = DET_CMD;
    endcase
  end

  always_comb begin
    s_cs_dec   = 1'b0;
    s_wen_dec  = 1'b0;
    s_char_dec = 8'h00;
    case (state_reg)
      DET_CMD: begin
        s_cs_dec   = 1'b1;
        s_wen_dec  = 1'b1;
        s_char_dec = 8'h5f;
      end
      DET_RD:  s_cs_dec = 1'b1;
      PR_CMD: begin
        s_cs_dec   = 1'b1;
        s_wen_dec  = 1'b1;
        s_char_dec = 8'h70;
      end
      PR_CHAR: begin
        s_cs_dec   = 1'b1;
        s_wen_dec  = 1'b1;
        s_char_dec = head_reg;
      end
      default: ;
    endcase
  end

  // The downstream port stays quiet while reset is held, whatever the state register says.
  assign s_cs   = s_cs_dec & reset;
  assign s_wen  = s_wen_dec & reset;
  assign s_addr = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sdin
      if (gi < 8) begin : g_char
        assign s_din[gi] = reset & s_char_dec[gi];
      end else begin : g_zero
        assign s_din[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    dout       = '0;
    dout[0]    = empty;
    dout[1]    = full;
    dout[2]    = reset & (state_reg != IDLE);
    dout[3]    = present_reg;
    dout[4]    = ovf_reg;
    dout[15:8] = 8'(count_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= DET_CMD;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      present_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
      if (state_reg == DET_RD) begin
        present_reg <= (s_dout[7:0] == 8'h21);
      end
      if (data_wr && full) begin
        ovf_reg <= 1'b1;
      end else if (ctrl_wr && din[1]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // Head is read one cycle ahead; it is stable across PR_CMD because nothing pops there.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din[7:0];
    end
    head_reg <= mem[rd_ptr_reg];
  end

  assign unused_bits = ^{din[WIDTH-1:8], s_dout[WIDTH-1:8]};

endmodule
